instruction_sequencer: RTL and testbench
========================================

# instruction_sequencer

Program memory plus fetch/issue controller that feeds the `cpu` core its `current_instruction` stream. Instructions are written over a load port, then a `start` pulse steps the program counter through them, presenting one 32-bit instruction at a time over a valid/ready handshake. Sequencing ends at the programmed length, at a HALT word, or on `stop`. Replaces bench-driven single-instruction stimulus as the CPU's instruction source.

## Interface
- `INSTRUCTION_WIDTH`, 32, instruction word width
- `PROGRAM_DEPTH`, 64, program memory words
- `ADDRESS_WIDTH`, `$clog2(PROGRAM_DEPTH)`, PC/address width
- `HALT_OPCODE`, 8'hFF, value of `instruction[31:24]` that ends the program
---
- `clock_in`  in  1  sole clock, rising edge
- `reset_in`  in  1  asynchronous, active-high reset
- `load_enable`  in  1  write `load_data` to `load_address` this cycle
- `load_address`  in  ADDRESS_WIDTH  program write address
- `load_data`  in  INSTRUCTION_WIDTH  program write data
- `program_length`  in  ADDRESS_WIDTH+1  instruction count, 0..PROGRAM_DEPTH
- `start`  in  1  begin sequencing from address 0
- `stop`  in  1  abort sequencing
- `current_instruction`  out  INSTRUCTION_WIDTH  instruction to CPU
- `instruction_valid`  out  1  `current_instruction` is valid
- `instruction_ready`  in  1  CPU accepts the instruction
- `program_counter`  out  ADDRESS_WIDTH  address of the current or next fetch
- `busy`  out  1  state is not IDLE
- `done`  out  1  one-cycle pulse on normal completion

## Operation
- States: IDLE, FETCH, ISSUE, DONE.
- IDLE: `load_enable` writes memory. `start` latches `program_length` into `length_q` and sets PC=0. Next state is FETCH, or DONE if `length_q`==0.
- FETCH: synchronous memory read of mem[PC] into the output register. Next state is ISSUE.
- ISSUE: if `current_instruction[31:24]`==HALT_OPCODE, `instruction_valid` stays 0, the word is not issued, and the next state is DONE. Otherwise `instruction_valid`=1. On valid&&ready, PC increments: if PC+1==`length_q`, go to DONE; otherwise go to FETCH.
- DONE: `done`=1 for exactly one cycle, then IDLE. PC holds its last value.
- `stop` in FETCH/ISSUE/DONE: go to IDLE next cycle with no `done` pulse. If `stop` coincides with a handshake, that instruction counts as accepted (PC increments) and no further instruction is issued.
- `start` outside IDLE is ignored. `load_enable` outside IDLE is ignored (write dropped).
- `stop` and `start` together in IDLE: `stop` wins, stay IDLE.
- PC width is ADDRESS_WIDTH. `length_q`==PROGRAM_DEPTH ends at PC = DEPTH−1 with no wrap (comparison is done at ADDRESS_WIDTH+1 bits).
- Memory contents are not cleared by reset.

## Timing
- Reset values: state IDLE, PC 0, `current_instruction` 0, `instruction_valid` 0, `busy` 0, `done` 0.
- `reset_in` mid-program: immediate return to IDLE and all outputs to reset values. The next `start` restarts from address 0.
- `start` at edge N: FETCH in cycle N+1, `instruction_valid` high in cycle N+2.
- Handshake: `current_instruction` is stable while valid&&!ready. `valid` never drops without a handshake (except on `stop`/reset).
- Throughput is one instruction per 2 cycles at ready=1. A k-instruction program asserts `done` in cycle N+2k+1.
- All outputs are registered; `busy` is decoded from registered state.
- A load write is visible to a FETCH one cycle later.

## Configuration
- `SEQUENCER_LOOP_EN` defined: reaching `length_q` wraps PC to 0 and goes to FETCH; no `done`. Only HALT, `stop` or reset end the run.
- Undefined: end of program goes to DONE as above. The wrap logic is absent.

## Test plan
- Load mem[0..2]=32'h01000001/32'h02000002/32'h03000003, length 3, ready=1, `start` -> valid in cycles N+2, N+4, N+6 with those words in order; `done` in N+7; PC=2.
- Same program with ready low for 3 cycles at the first valid -> word 32'h01000001 held stable for 4 cycles; no PC change until ready.
- mem[1]=32'hFF000000, length 3 -> only word 0 issued; `done` one cycle after the HALT ISSUE; valid never high with 32'hFF000000.
- `stop` asserted during the second ISSUE with ready=0 -> IDLE next cycle, valid=0, no `done`. `reset_in` pulse mid-run -> outputs 0 asynchronously.
- length 0 `start` -> `done` at N+1, no valid. `load_enable` while busy -> memory unchanged when read back later.
- With `SEQUENCER_LOOP_EN`, length 2 -> sequence 0,1,0,1… until `stop`; no `done` pulse.

Source files
------------

// File: rtl/instruction_sequencer.sv
// instruction_sequencer
//   Program memory plus fetch/issue controller feeding the CPU core.
//   A program is written through the load port while idle. A start pulse
//   walks the PC from address 0 and presents one instruction at a time over
//   a valid/ready handshake. The run ends at program_length, at a HALT word
//   (top byte == HALT_OPCODE, never issued) or on stop.
//
//   Optional feature macro: SEQUENCER_LOOP_EN
//     defined   : reaching program_length wraps PC to 0 and keeps fetching
//     undefined : reaching program_length finishes with a done pulse
//
// Ports
//   clock_in, reset_in              clock, async active-high reset
//   load_enable/address/data        program write port (honoured in IDLE only)
//   program_length                  instruction count, latched on start
//   start, stop                     run control (stop wins over start)
//   current_instruction, instruction_valid, instruction_ready
//                                   instruction handshake to the CPU
//   program_counter                 address of current or next fetch
//   busy                            sequencer not idle
//   done                            one-cycle pulse on normal completion
module instruction_sequencer #(
    parameter int              INSTRUCTION_WIDTH = 32,
    parameter int              PROGRAM_DEPTH     = 64,
    parameter int              ADDRESS_WIDTH     = $clog2(PROGRAM_DEPTH),
    parameter logic [7:0]      HALT_OPCODE       = 8'hFF
) (
    input  logic                         clock_in,
    input  logic                         reset_in,
    input  logic                         load_enable,
    input  logic [ADDRESS_WIDTH-1:0]     load_address,
    input  logic [INSTRUCTION_WIDTH-1:0] load_data,
    input  logic [ADDRESS_WIDTH:0]       program_length,
    input  logic                         start,
    input  logic                         stop,
    output logic [INSTRUCTION_WIDTH-1:0] current_instruction,
    output logic                         instruction_valid,
    input  logic                         instruction_ready,
    output logic [ADDRESS_WIDTH-1:0]     program_counter,
    output logic                         busy,
    output logic                         done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [ADDRESS_WIDTH-1:0] PC_ONE  = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDRESS_WIDTH:0]   LEN_ONE = {{ADDRESS_WIDTH{1'b0}}, 1'b1};

    logic [1:0]                   state;
    logic [ADDRESS_WIDTH:0]       length_q;
    logic [INSTRUCTION_WIDTH-1:0] mem [PROGRAM_DEPTH];
    logic [INSTRUCTION_WIDTH-1:0] rd_word;
    logic                         handshake;
    logic                         last_word;

    assign rd_word   = mem[program_counter];
    assign handshake = (state == S_ISSUE) && instruction_valid && instruction_ready;
    // Compared one bit wider than the PC so a full-depth program ends at
    // DEPTH-1 instead of wrapping.
    assign last_word = (({1'b0, program_counter} + LEN_ONE) == length_q);
    assign busy      = (state != S_IDLE);

    // Program memory: no reset, contents survive reset_in.
    always_ff @(posedge clock_in) begin
        if (state == S_IDLE && load_enable)
            mem[load_address] <= load_data;
    end

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            state               <= S_IDLE;
            length_q            <= '0;
            program_counter     <= '0;
            current_instruction <= '0;
            instruction_valid   <= 1'b0;
            done                <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && !stop) begin
                        length_q        <= program_length;
                        program_counter <= '0;
                        if (program_length == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    if (stop) begin
                        state <= S_IDLE;
                    end else begin
                        // Valid is decided here so it is a registered output;
                        // a HALT word is loaded but never marked valid.
                        current_instruction <= rd_word;
                        instruction_valid   <= (rd_word[INSTRUCTION_WIDTH-1 -: 8] != HALT_OPCODE);
                        state               <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (handshake) begin
                        instruction_valid <= 1'b0;
                        if (last_word) begin
`ifdef SEQUENCER_LOOP_EN
                            program_counter <= '0;
                            state           <= S_FETCH;
`else
                            state <= S_DONE;
                            done  <= 1'b1;
`endif
                        end else begin
                            program_counter <= program_counter + PC_ONE;
                            state           <= S_FETCH;
                        end
                    end else if (!instruction_valid) begin
                        // HALT word sitting in the output register
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                    // A coincident handshake still advances the PC above.
                    if (stop) begin
                        state             <= S_IDLE;
                        instruction_valid <= 1'b0;
                        done              <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_sequencer.sv
module tb_instruction_sequencer;

    localparam logic [31:0] W0   = 32'h01000001;
    localparam logic [31:0] W1   = 32'h02000002;
    localparam logic [31:0] W2   = 32'h03000003;
    localparam logic [31:0] HALT = 32'hFF000000;

    logic        clk = 1'b0;
    logic        reset_in;
    logic        load_enable;
    logic [5:0]  load_address;
    logic [31:0] load_data;
    logic [6:0]  program_length;
    logic        start, stop;
    logic [31:0] current_instruction;
    logic        instruction_valid;
    logic        instruction_ready;
    logic [5:0]  program_counter;
    logic        busy, done;

    instruction_sequencer dut (
        .clock_in            (clk),
        .reset_in            (reset_in),
        .load_enable         (load_enable),
        .load_address        (load_address),
        .load_data           (load_data),
        .program_length      (program_length),
        .start               (start),
        .stop                (stop),
        .current_instruction (current_instruction),
        .instruction_valid   (instruction_valid),
        .instruction_ready   (instruction_ready),
        .program_counter     (program_counter),
        .busy                (busy),
        .done                (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] word;
        int          off;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   done_cnt = 0;
    int   done_off = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every accepted instruction is popped and checked for
    // content and for the cycle (relative to the start edge) it was taken.
    always @(negedge clk) begin
        if (!reset_in) begin
            if (instruction_valid)
                chk("halt_word_valid", {31'b0, current_instruction[31:24] == 8'hFF}, 32'd0);
            if (instruction_valid && instruction_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_issue", current_instruction, 32'h0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("issue_word", current_instruction, e.word);
                    chk("issue_cycle", cyc - start_cyc, e.off);
                end
            end
            if (done) begin
                done_cnt++;
                done_off = cyc - start_cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [5:0] a, input logic [31:0] d);
        load_enable  = 1'b1;
        load_address = a;
        load_data    = d;
        tick();
        load_enable  = 1'b0;
    endtask

    task automatic push(input logic [31:0] w, input int off);
        exp_t e;
        e.word = w;
        e.off  = off;
        exp_q.push_back(e);
    endtask

    // start is sampled at edge N; offset 0 is the period after edge N.
    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (busy && k < 100) begin
            tick();
            k++;
        end
        chk(tag, {31'b0, k >= 100}, 32'd0);
    endtask

    task automatic run_full(input string tag);
        int d0;
        d0 = done_cnt;
        program_length    = 7'd3;
        instruction_ready = 1'b1;
        push(W0, 1);
        push(W1, 3);
        push(W2, 5);
        do_start();
        wait_idle({tag, "_timeout"});
        chk({tag, "_done_cnt"}, done_cnt - d0, 1);
        chk({tag, "_done_cycle"}, done_off, 6);
        chk({tag, "_pc"}, {26'b0, program_counter}, 32'd2);
        chk({tag, "_sb_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        int d0;
        reset_in          = 1'b1;
        load_enable       = 1'b0;
        load_address      = '0;
        load_data         = '0;
        program_length    = '0;
        start             = 1'b0;
        stop              = 1'b0;
        instruction_ready = 1'b0;
        tick();
        tick();
        chk("rst_valid", {31'b0, instruction_valid}, 0);
        chk("rst_instr", current_instruction, 0);
        chk("rst_pc", {26'b0, program_counter}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_done", {31'b0, done}, 0);
        reset_in = 1'b0;
        tick();

        load(6'd0, W0);
        load(6'd1, W1);
        load(6'd2, W2);

        // basic 3-word program
        run_full("basic");

        // back-pressure on the first word
        program_length    = 7'd3;
        instruction_ready = 1'b0;
        push(W0, 4);
        push(W1, 6);
        push(W2, 8);
        do_start();
        for (int i = 1; i <= 3; i++) begin
            tick();
            @(negedge clk);
            chk("bp_valid", {31'b0, instruction_valid}, 1);
            chk("bp_word", current_instruction, W0);
            chk("bp_pc", {26'b0, program_counter}, 0);
        end
        tick();
        instruction_ready = 1'b1;
        wait_idle("bp_timeout");
        chk("bp_done_cycle", done_off, 9);
        chk("bp_pc_end", {26'b0, program_counter}, 2);

        // HALT in word 1
        load(6'd1, HALT);
        d0 = done_cnt;
        program_length = 7'd3;
        push(W0, 1);
        do_start();
        wait_idle("halt_timeout");
        chk("halt_done_cnt", done_cnt - d0, 1);
        chk("halt_done_cycle", done_off, 4);
        chk("halt_pc", {26'b0, program_counter}, 1);
        chk("halt_sb_empty", exp_q.size(), 0);
        load(6'd1, W1);

        // stop during the second ISSUE with ready low
        d0 = done_cnt;
        instruction_ready = 1'b1;
        push(W0, 1);
        do_start();
        tick();
        tick();
        instruction_ready = 1'b0;
        tick();
        @(negedge clk);
        chk("stop_valid_before", {31'b0, instruction_valid}, 1);
        chk("stop_word_before", current_instruction, W1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_valid", {31'b0, instruction_valid}, 0);
        chk("stop_busy", {31'b0, busy}, 0);
        chk("stop_pc", {26'b0, program_counter}, 1);
        tick();
        tick();
        chk("stop_no_done", done_cnt - d0, 0);

        // asynchronous reset mid-run
        instruction_ready = 1'b1;
        push(W0, 1);
        do_start();
        tick();
        @(negedge clk);
        #1;
        reset_in = 1'b1;
        #1;
        chk("arst_valid", {31'b0, instruction_valid}, 0);
        chk("arst_instr", current_instruction, 0);
        chk("arst_pc", {26'b0, program_counter}, 0);
        chk("arst_busy", {31'b0, busy}, 0);
        chk("arst_sb_empty", exp_q.size(), 0);
        tick();
        reset_in = 1'b0;
        tick();
        run_full("after_rst");

        // zero-length program
        d0 = done_cnt;
        program_length = 7'd0;
        do_start();
        wait_idle("len0_timeout");
        chk("len0_done_cnt", done_cnt - d0, 1);
        chk("len0_done_cycle", done_off, 0);
        chk("len0_no_valid", {31'b0, instruction_valid}, 0);

        // writes while busy are dropped
        program_length    = 7'd3;
        instruction_ready = 1'b0;
        do_start();
        load(6'd2, 32'hDEADBEEF);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("busyload_idle", {31'b0, busy}, 0);
        run_full("busyload");

`ifdef SEQUENCER_LOOP_EN
        d0 = done_cnt;
        program_length    = 7'd2;
        instruction_ready = 1'b1;
        push(W0, 1);
        push(W1, 3);
        push(W0, 5);
        push(W1, 7);
        do_start();
        for (int i = 0; i < 8; i++) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("loop_no_done", done_cnt - d0, 0);
        chk("loop_idle", {31'b0, busy}, 0);
        chk("loop_sb_empty", exp_q.size(), 0);
`endif

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
